// File: rtl/spi_frame_tx_pkg.sv
// Shared definitions for the SPI frame transmitter: FSM state encoding and the
// counter-width helper used by the transmitter and its clock divider.
package spi_frame_tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        HOLD  = ST_HOLD,
        GAP   = ST_GAP
    } state_t;

    // Bits needed to hold every value 0..max_count inclusive.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/spi_frame_tx_if.sv
// Frame handshake between a producer and the SPI frame transmitter.
interface spi_frame_tx_if #(
    parameter int NB = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [NB-1:0] in_data;
    logic          abort;

    modport master (output in_valid, in_data, abort, input in_ready);
    modport slave  (input in_valid, in_data, abort, output in_ready);
endinterface

// File: rtl/spi_clk_div.sv
// Half-period counter for the serial clock: tick ends each half-period,
// rise/fall mark the ends of the low and high halves respectively.
module spi_clk_div
    import spi_frame_tx_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick,
    output logic rise,
    output logic fall
);
    localparam int            CW   = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          phase;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!run) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == LAST);
    assign rise = tick && !phase;
    assign fall = tick && phase;

endmodule

// File: rtl/spi_frame_tx.sv
// Shifts one frame of cascaded device words out over SPI with a cs_n load
// strobe, fixed hold and gap phases, abort and a completion pulse.
module spi_frame_tx
    import spi_frame_tx_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int N_DEV     = 1,
    parameter int CLK_DIV   = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_frame_tx_if.slave bus,
    output logic         sclk,
    output logic         mosi,
    output logic         cs_n,
    output logic         busy,
    output logic         done
);
    localparam int            NB       = WIDTH * N_DEV;
    localparam int            BW       = cnt_width(NB);
    localparam logic [BW-1:0] LAST_BIT = BW'(NB - 1);

    state_t        state;
    logic [NB-1:0] sr;
    logic [NB-1:0] sr_next;
    logic [BW-1:0] bit_cnt;
    logic          in_ready_q;
    logic          accept;
    logic          take_abort;
    logic          run;
    logic          tick;
    logic          rise;
    logic          fall;

    function automatic logic first_bit(input logic [NB-1:0] v);
        return MSB_FIRST ? v[NB-1] : v[0];
    endfunction

    // in_ready_q is high exactly in IDLE, so it doubles as the state qualifier.
    assign accept     = in_ready_q && bus.in_valid;
    assign take_abort = bus.abort && (state == SHIFT || state == HOLD);
    assign run        = (state != IDLE) && !take_abort;
    assign sr_next    = MSB_FIRST ? (sr << 1) : (sr >> 1);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (run),
        .tick (tick),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            in_ready_q <= 1'b1;
            cs_n       <= 1'b1;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (take_abort) begin
                sclk    <= 1'b0;
                mosi    <= 1'b0;
                cs_n    <= 1'b1;
                bit_cnt <= '0;
                state   <= GAP;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        sr         <= bus.in_data;
                        mosi       <= first_bit(bus.in_data);
                        cs_n       <= 1'b0;
                        in_ready_q <= 1'b0;
                        state      <= SHIFT;
                    end
                    SHIFT: if (rise) begin
                        sclk <= 1'b1;
                    end else if (fall) begin
                        sclk <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            mosi    <= 1'b0;
                            state   <= HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            sr      <= sr_next;
                            mosi    <= first_bit(sr_next);
                        end
                    end
                    HOLD: if (tick) begin
                        cs_n  <= 1'b1;
                        done  <= 1'b1;
                        state <= GAP;
                    end
                    GAP: if (tick) begin
                        in_ready_q <= 1'b1;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready = in_ready_q;
    assign busy         = ~in_ready_q;

endmodule
